// File: rtl/alu_sequencer.sv
// Operand/opcode sequencer for the combinational ALU: captures A, B, OP from a shared bus
// on enter rising edges, latches the result one cycle later. Optional feature: ALU_SEQ_ACCUM_EN.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enter,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_op,
    input  logic [WIDTH:0]   alu_result,
    input  logic             alu_error,
    output logic [WIDTH:0]   result_q,
    output logic             error_q,
    output logic             done,
    output logic             op_invalid,
    output logic [2:0]       state_o,
    output logic [WIDTH:0]   disp_value
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t state, state_nx;
    logic   enter_d, enter_rise;
    logic   ld_a, ld_b, ld_op, op_bad, ld_res, ld_acc;

    assign enter_rise = enter & ~enter_d;
    assign state_o    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= WAIT_A;
            enter_d <= 1'b0;
        end else begin
            state   <= state_nx;
            enter_d <= enter;
        end
    end

    always_comb begin
        state_nx = state;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_op    = 1'b0;
        op_bad   = 1'b0;
        ld_res   = 1'b0;
        ld_acc   = 1'b0;
        if (clear) begin
            state_nx = WAIT_A;
        end else begin
            case (state)
                WAIT_A: if (enter_rise) begin
                    ld_a     = 1'b1;
                    state_nx = WAIT_B;
                end
                WAIT_B: if (enter_rise) begin
                    ld_b     = 1'b1;
                    state_nx = WAIT_OP;
                end
                WAIT_OP: if (enter_rise) begin
                    if (data_in <= WIDTH'(3)) begin
                        ld_op    = 1'b1;
                        state_nx = EXEC;
                    end else begin
                        op_bad   = 1'b1;
                    end
                end
                // One cycle only; an enter edge seen here is dropped.
                EXEC: begin
                    ld_res   = 1'b1;
                    state_nx = SHOW;
                end
                SHOW: if (enter_rise) begin
`ifdef ALU_SEQ_ACCUM_EN
                    ld_acc   = 1'b1;
                    state_nx = WAIT_B;
`else
                    state_nx = WAIT_A;
`endif
                end
                default: state_nx = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
            op_invalid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= ld_res;
            if (clear) begin
                alu_a      <= '0;
                alu_b      <= '0;
                alu_op     <= '0;
                result_q   <= '0;
                error_q    <= 1'b0;
                op_invalid <= 1'b0;
            end else begin
                if (ld_a)   alu_a <= data_in;
                // Chaining drops the carry bit; error_q stays until the next EXEC.
                if (ld_acc) alu_a <= result_q[WIDTH-1:0];
                if (ld_b)   alu_b <= data_in;
                if (ld_op) begin
                    alu_op     <= data_in;
                    op_invalid <= 1'b0;
                end
                if (op_bad) op_invalid <= 1'b1;
                if (ld_res) begin
                    result_q <= alu_result;
                    error_q  <= alu_error;
                end
            end
        end
    end

    always_comb begin
        disp_value = '0;
        case (state)
            WAIT_B:       disp_value = {1'b0, alu_a};
            WAIT_OP:      disp_value = {1'b0, alu_b};
            EXEC, SHOW:   disp_value = result_q;
            default:      disp_value = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; includes a behavioural model of the 16-bit ALU it drives.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] data_in = '0;
    logic        enter = 1'b0;
    logic [15:0] alu_a, alu_b, alu_op;
    logic [16:0] alu_result;
    logic        alu_error;
    logic [16:0] result_q;
    logic        error_q, done, op_invalid;
    logic [2:0]  state_o;
    logic [16:0] disp_value;

    int pass_cnt = 0;
    int total    = 0;

    alu_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .enter(enter),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_error(alu_error),
        .result_q(result_q), .error_q(error_q), .done(done), .op_invalid(op_invalid),
        .state_o(state_o), .disp_value(disp_value)
    );

    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            16'd0:   alu_result = {1'b0, alu_a} + {1'b0, alu_b};
            16'd1:   alu_result = {1'b0, alu_a} - {1'b0, alu_b};
            16'd2:   alu_result = {1'b0, alu_a & alu_b};
            16'd3:   alu_result = {1'b0, alu_a | alu_b};
            default: alu_result = '0;
        endcase
        alu_error = (alu_op < 16'd2) ? alu_result[16] : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse enter for one cycle with value v; returns on the negedge after the capturing edge.
    task automatic enter_val(input logic [15:0] v);
        @(negedge clk);
        data_in = v;
        enter   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Full A/B/OP entry from WAIT_A, checking latency and latched outputs.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] op, input logic [16:0] exp_res, input logic exp_err);
        enter_val(a);
        chk({tag, ".stB"}, state_o, 1);
        chk({tag, ".dispA"}, disp_value, {1'b0, a});
        enter_val(b);
        chk({tag, ".stOP"}, state_o, 2);
        chk({tag, ".dispB"}, disp_value, {1'b0, b});
        enter_val(op);
        chk({tag, ".stEX"}, state_o, 3);
        chk({tag, ".done0"}, done, 0);
        @(negedge clk);
        chk({tag, ".stSHOW"}, state_o, 4);
        chk({tag, ".done1"}, done, 1);
        chk({tag, ".res"}, result_q, exp_res);
        chk({tag, ".err"}, error_q, exp_err);
        chk({tag, ".disp"}, disp_value, exp_res);
        @(negedge clk);
        chk({tag, ".doneoff"}, done, 0);
    endtask

    initial begin
        #1;
        chk("rst.state", state_o, 0);
        chk("rst.a", alu_a, 0);
        chk("rst.res", result_q, 0);
        chk("rst.done", done, 0);
        chk("rst.disp", disp_value, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("add", 16'h0005, 16'h0003, 16'd0, 17'h00008, 1'b0);
        chk("add.op", alu_op, 0);
`ifdef ALU_SEQ_ACCUM_EN
        do_clear();
`else
        enter_val(16'h0000);
        chk("show2a.state", state_o, 0);
        chk("show2a.keep", result_q, 17'h00008);
`endif
        run_op("ovf", 16'hFFFF, 16'h0001, 16'd0, 17'h10000, 1'b1);
        do_clear();
        chk("clr.res", result_q, 0);
        run_op("sub", 16'h0003, 16'h0005, 16'd1, 17'h1FFFE, 1'b1);
        do_clear();
        run_op("and", 16'h00F0, 16'h0FF0, 16'd2, 17'h000F0, 1'b0);
        do_clear();

        // Rejected opcode then a valid one
        enter_val(16'h0001);
        enter_val(16'h0002);
        enter_val(16'h0007);
        chk("inv.state", state_o, 2);
        chk("inv.flag", op_invalid, 1);
        chk("inv.op", alu_op, 0);
        enter_val(16'h0003);
        chk("inv2.state", state_o, 3);
        chk("inv2.flag", op_invalid, 0);
        chk("inv2.op", alu_op, 3);
        @(negedge clk);
        chk("inv2.res", result_q, 17'h00003);
        do_clear();

        // Enter held for 10 cycles advances once
        @(negedge clk);
        data_in = 16'h0009;
        enter   = 1'b1;
        repeat (10) @(negedge clk);
        enter   = 1'b0;
        chk("hold.state", state_o, 1);
        chk("hold.a", alu_a, 16'h0009);

        // Async reset in WAIT_OP, no clock edge needed
        enter_val(16'h0004);
        chk("pre.state", state_o, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst.state", state_o, 0);
        chk("arst.a", alu_a, 0);
        chk("arst.b", alu_b, 0);
        chk("arst.disp", disp_value, 0);
        @(negedge clk);
        reset = 1'b0;

        // Clear wins over a simultaneous enter rise
        enter_val(16'h0011);
        chk("clrpri.pre", state_o, 1);
        @(negedge clk);
        data_in = 16'h0022;
        enter   = 1'b1;
        clear   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
        clear   = 1'b0;
        chk("clrpri.state", state_o, 0);
        chk("clrpri.a", alu_a, 0);
        chk("clrpri.b", alu_b, 0);

        // SHOW behaviour with and without chaining
        run_op("two", 16'h0002, 16'h0003, 16'd0, 17'h00005, 1'b0);
        enter_val(16'h0000);
`ifdef ALU_SEQ_ACCUM_EN
        chk("acc.state", state_o, 1);
        chk("acc.a", alu_a, 16'h0005);
        enter_val(16'h0004);
        enter_val(16'h0000);
        @(negedge clk);
        chk("acc.res", result_q, 17'h00009);
        chk("acc.stSHOW", state_o, 4);
`else
        chk("noacc.state", state_o, 0);
        chk("noacc.a", alu_a, 16'h0002);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operand/opcode sequencer for the 16-bit combinational ALU. It captures A, B and OP one at a time from a shared 16-bit input bus, using rising edges of a debounced `enter` level. It drives the ALU operand ports from registers, latches the 17-bit result and carry/borrow error one cycle later, and presents a display value for the board's 7-segment driver. It sits between the debounced switch/button logic and the ALU instance.

## Interface
Parameters:
- `WIDTH`, 16: operand width. The ALU result is `WIDTH+1` bits.

Ports:
- `clk`  in  1  system clock. All state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous abort. Returns to WAIT_A and zeroes all data registers.
- `data_in`  in  WIDTH  switch bus. Sampled as A, B or OP depending on state.
- `enter`  in  1  debounced button level. Only its rising edge is used.
- `alu_a`, `alu_b`, `alu_op`  out  WIDTH each  registered drive to the ALU `A`, `B` and `OP` ports.
- `alu_result`  in  WIDTH+1  ALU `result`.
- `alu_error`  in  1  ALU `error`.
- `result_q`  out  WIDTH+1  latched result.
- `error_q`  out  1  latched error.
- `done`  out  1  one-cycle pulse when `result_q` is updated.
- `op_invalid`  out  1  sticky flag: the last OP entry was rejected.
- `state_o`  out  3  current state encoding, for the LEDs.
- `disp_value`  out  WIDTH+1  value to display.

## Operation
- Edge detect: `enter_d` register. `enter_rise = enter & ~enter_d`. Holding `enter` high gives exactly one event.
- States and encodings: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4.
- WAIT_A, on `enter_rise`: `alu_a <= data_in`, go to WAIT_B.
- WAIT_B, on `enter_rise`: `alu_b <= data_in`, go to WAIT_OP.
- WAIT_OP, on `enter_rise`:
  - If `data_in <= 3`: `alu_op <= data_in`, clear `op_invalid`, go to EXEC.
  - Otherwise: set `op_invalid`, stay in WAIT_OP, leave `alu_op` unchanged.
- EXEC (unconditional, one cycle): `result_q <= alu_result`, `error_q <= alu_error`, `done` = 1, go to SHOW.
- SHOW, on `enter_rise`: go to WAIT_A. Registers are kept until overwritten.
- `disp_value` (combinational from registers):
  - WAIT_A: 0.
  - WAIT_B: zero-extended `alu_a`.
  - WAIT_OP: zero-extended `alu_b`.
  - EXEC: `result_q` (previous value).
  - SHOW: `result_q`.
- Arithmetic is entirely inside the ALU. Opcodes: 0 = A+B, 1 = A−B, 2 = A&B, 3 = A|B. `error` = bit WIDTH of the result for add/sub, 0 otherwise. The block never modifies the result.
- `clear` takes priority over `enter_rise` in every state. It zeroes `alu_a`, `alu_b`, `alu_op`, `result_q`, `error_q` and `op_invalid`, and sets state to WAIT_A. `enter_d` still tracks `enter`.
- Any unused state encoding (5–7) goes to WAIT_A on the next clock.

## Timing
- Reset values: state WAIT_A, every output register 0, `enter_d` = 0, `done` = 0, `disp_value` = 0.
- `enter` rising between edges k−1 and k: the transition happens at edge k.
- OP accepted at edge k: `alu_op` valid after k. `result_q`, `error_q` and `done` are updated at edge k+1, and `done` is high during cycle k+1..k+2. Latency from the OP-accept edge is 1 cycle; SHOW is entered at k+1.
- `enter_rise` during EXEC is ignored (consumed, not queued).
- `reset` asserted mid-sequence clears everything immediately, with no clock needed. After release, the first event requires a fresh rising edge of `enter`. If `enter` is high at release, that counts as a rise because `enter_d` resets to 0.

## Configuration
- `ALU_SEQ_ACCUM_EN` defined: in SHOW, `enter_rise` loads `alu_a <= result_q[WIDTH-1:0]` and goes to WAIT_B, which chains operations. The carry bit is dropped; `error_q` is held until the next EXEC.
- Undefined: SHOW → WAIT_A as described above.

## Test plan
- Add: A=0x0005, B=0x0003, OP=0 → `result_q`=0x00008, `error_q`=0, `done` pulse 1 cycle after OP edge, state 4.
- Add overflow: A=0xFFFF, B=0x0001, OP=0 → `result_q`=0x10000, `error_q`=1.
- Subtract borrow and logic ops: 0x0003−0x0005 → 0x1FFFE, `error_q`=1. 0x00F0 & 0x0FF0 → 0x000F0, `error_q`=0.
- Invalid OP 0x0007 → stays in WAIT_OP, `op_invalid`=1, `alu_op` unchanged. Then OP=3 → EXEC, `op_invalid`=0.
- Hold `enter` high for 10 cycles in WAIT_A → exactly one advance, to WAIT_B. `reset` pulse in WAIT_OP → all outputs 0, state 0 without a clock edge. `clear` together with an `enter` rise → WAIT_A.
- With `ALU_SEQ_ACCUM_EN`: 2+3, then `enter` in SHOW → state WAIT_B with `alu_a`=0x0005. B=0x0004, OP=0 → `result_q`=0x00009.
